// File: rtl/day4_pkg.sv
// Day 4 shared definitions: grid size defaults, access threshold,
// FSM state encoding and the index-width helper.
package day4_pkg;

  localparam int COLS_DEF   = 136;
  localparam int ROWS_DEF   = 136;
  localparam int THRESH_DEF = 4;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Bits needed to hold the values 0 .. n-1.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/day4_popcount8.sv
// Combinational popcount of 8 neighbour bits.
// Ports: bits[7:0] in, count[3:0] out (0..8).
module day4_popcount8 (
  input  logic [7:0] bits,
  output logic [3:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++)
      count = count + {3'b000, bits[i]};
  end

endmodule

// File: rtl/day4_neighbor_window.sv
// Streaming 3x3 neighbour window over a row-major roll grid.
// Ports: clk, rst; in_valid/in_ready/in_cell; out_valid/out_ready/out_count/out_access/out_last; busy.
module day4_neighbor_window
  import day4_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_cell,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_count,
  output logic       out_access,
  output logic       out_last,
  output logic       busy
);

  localparam int N   = ROWS * COLS;
  localparam int CHW = 2 * COLS + 3;
  localparam int IW  = idx_w(N + COLS + 1);
  localparam int CW  = idx_w(COLS);
  localparam int RW  = idx_w(ROWS);

  localparam logic [IW-1:0] I_EMIT   = IW'(COLS + 1);
  localparam logic [IW-1:0] I_LASTIN = IW'(N - 1);
  localparam logic [IW-1:0] I_LASTFL = IW'(N + COLS);
  localparam logic [CW-1:0] C_MAX    = CW'(COLS - 1);
  localparam logic [RW-1:0] R_MAX    = RW'(ROWS - 1);
  localparam logic [3:0]    TH       = 4'(THRESH);

  logic [1:0]     state;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  ccol;
  logic [RW-1:0]  crow;
  logic [CHW-2:0] sr;
  logic [CHW-1:0] win;
  logic [7:0]     nb;
  logic [3:0]     cnt;
  logic           stall;
  logic           advance;
  logic           emit;
  logic           din;
  logic           done;
  logic           first_col;
  logic           last_col;
  logic           first_row;

  assign stall   = out_valid & ~out_ready;
  assign advance = ~stall &
                   ((state == ST_RUN & in_valid) |
                    state == ST_FLUSH);
  assign in_ready = ~rst & (state == ST_RUN) & ~stall;
  assign emit     = advance & (idx >= I_EMIT);
  assign din      = (state == ST_RUN) & in_cell;

  // Window as it will look after this shift: the
  // stored chain plus the incoming bit at tap 0.
  assign win = {sr, din};

  assign first_col = (ccol == '0);
  assign last_col  = (ccol == C_MAX);
  assign first_row = (crow == '0);

  // Stale chain contents (reset, wrap-around) only
  // ever reach masked taps.
  assign nb = {
    win[2*COLS+2] & ~first_row & ~first_col,
    win[2*COLS+1] & ~first_row,
    win[2*COLS]   & ~first_row & ~last_col,
    win[COLS+2]   & ~first_col,
    win[COLS]     & ~last_col,
    win[2]        & ~first_col,
    win[1],
    win[0]        & ~last_col
  };

  day4_popcount8 u_pop (
    .bits  (nb),
    .count (cnt)
  );

  assign done = (state == ST_DRAIN) & out_valid &
                out_ready & out_last;

  always_ff @(posedge clk) begin
    if (advance)
      sr <= win[CHW-2:0];
  end

  always_ff @(posedge clk) begin
    if (rst || done) begin
      state <= ST_RUN;
      idx   <= '0;
      ccol  <= '0;
      crow  <= '0;
      busy  <= 1'b0;
    end else begin
      if (advance) begin
        idx <= idx + 1'b1;
        if (state == ST_RUN)
          busy <= 1'b1;
        if (state == ST_RUN && idx == I_LASTIN)
          state <= ST_FLUSH;
        if (state == ST_FLUSH && idx == I_LASTFL)
          state <= ST_DRAIN;
      end
      if (emit) begin
        if (last_col) begin
          ccol <= '0;
          crow <= crow + 1'b1;
        end else begin
          ccol <= ccol + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_count  <= '0;
      out_access <= 1'b0;
      out_last   <= 1'b0;
    end else if (emit) begin
      out_valid  <= 1'b1;
      out_count  <= cnt;
      out_access <= win[COLS+1] & (cnt < TH);
      out_last   <= (crow == R_MAX) & last_col;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
